fifo_rd_stream_adapter: RTL and testbench

Read-side adapter between the synchronous FIFO and a downstream valid/ready consumer. The FIFO returns `data_out` one cycle after `rd_en`, so the adapter issues reads only when it has credit. It catches the returned words in a 2-entry skid buffer and presents them as a loss-free stream that tolerates back-pressure. It also checks the FIFO `underflow` flag on every returned word and keeps optional statistics.

---
 rtl/fifo_rd_stream_adapter.sv | 152 +++++++++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream_adapter
// Description : Read-side adapter between a synchronous FIFO (one-cycle read
//               latency) and a valid/ready stream consumer. Reads are issued
//               only when the 2-entry skid buffer has room for the returned
//               word, so nothing is lost under back-pressure. Returned words
//               flagged by fifo_underflow are discarded and recorded.
// Ports       : clk, rst_n (async, active-low), flush (sync drop of buffered
//               and in-flight words); FIFO side: fifo_data_out, fifo_empty,
//               fifo_underflow in, fifo_rd_en out; stream side: m_data,
//               m_valid out, m_ready in; status: underflow_seen (sticky),
//               beat_cnt, underflow_cnt (saturating statistics).
// Config      : define FIFO_RD_ADAPTER_STATS_EN to build the statistics
//               counters; otherwise beat_cnt/underflow_cnt read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream_adapter #(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  underflow_seen,
    output logic [15:0]           beat_cnt,
    output logic [15:0]           underflow_cnt
);

    // Skid occupancy; the encoding equals the number of held words.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  inflight_q;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [FIFO_WIDTH-1:0] mem_q [2];
    logic                  uf_seen_q;

    logic                  pop;
    logic                  push;
    logic                  uf_drop;
    logic [2:0]            held;

    assign pop = m_valid & m_ready;

    // A return landing in the flush cycle is neither stored nor counted.
    assign push    = inflight_q & ~flush & ~fifo_underflow;
    assign uf_drop = inflight_q & ~flush &  fifo_underflow;

    // Words that will be owned after this edge if a read is not issued now.
    // pop implies at least one buffered word, so this never goes negative.
    assign held = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            uf_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (push) begin
                mem_q[tail_q] <= fifo_data_out;
            end
            if (uf_drop) begin
                uf_seen_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ push;
        if (flush) begin
            state_d = S_EMPTY;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: if (push)          state_d = S_ONE;
                S_ONE: begin
                    if (push && !pop)       state_d = S_TWO;
                    else if (pop && !push)  state_d = S_EMPTY;
                end
                S_TWO:   if (pop && !push)  state_d = S_ONE;
                default:                    state_d = S_EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        m_valid    = (state_q != S_EMPTY);
        m_data     = mem_q[head_q];
        // Combinational through m_ready so a full buffer being drained
        // this cycle can still keep the read pipeline busy.
        fifo_rd_en = rst_n & ~flush & ~fifo_empty & (held < 3'd2);
    end

    assign underflow_seen = uf_seen_q;

`ifdef FIFO_RD_ADAPTER_STATS_EN
    logic [15:0] beat_cnt_q;
    logic [15:0] uf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            uf_cnt_q   <= '0;
        end else begin
            if (pop && (beat_cnt_q != 16'hFFFF)) begin
                beat_cnt_q <= beat_cnt_q + 16'd1;
            end
            if (uf_drop && (uf_cnt_q != 16'hFFFF)) begin
                uf_cnt_q <= uf_cnt_q + 16'd1;
            end
        end
    end

    assign beat_cnt      = beat_cnt_q;
    assign underflow_cnt = uf_cnt_q;
`else
    assign beat_cnt      = 16'd0;
    assign underflow_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream_adapter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fifo_rd_stream_adapter
// Description : Scoreboard bench for fifo_rd_stream_adapter. A queue-based
//               FIFO model feeds the adapter; words returned to the adapter
//               enter an expected queue, and a negedge monitor compares the
//               stream against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream_adapter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [W-1:0] fifo_data_out;
    logic         fifo_empty;
    logic         fifo_underflow;
    logic         fifo_rd_en;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         underflow_seen;
    logic [15:0]  beat_cnt;
    logic [15:0]  underflow_cnt;

    always #5 clk = ~clk;

    fifo_rd_stream_adapter #(.FIFO_WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .underflow_seen (underflow_seen),
        .beat_cnt       (beat_cnt),
        .underflow_cnt  (underflow_cnt)
    );

    // FIFO model storage: written by the stimulus, read by the model.
    logic [W-1:0] fmem [0:1023];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    logic         uf_arm;
    logic [W-1:0] uf_word;

    // Reference model state
    logic         ret_pend;
    logic [W-1:0] exp_q [$];
    logic         exp_uf_seen;
    int           exp_beats;
    int           exp_ufc;
    int           cyc = 0;

    // Monitor logs
    logic [W-1:0] dlv_data [$];
    int           dlv_cyc [$];
    int           rd_cyc [$];

    // Directed-check requests: produced by stimulus, compared by monitor.
    typedef struct {
        string name;
        int    act;
        int    expv;
    } chk_t;
    chk_t req_arr [0:255];
    int   req_wr = 0;
    int   req_rd = 0;

    int tests = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO with one-cycle read latency plus expected-stream bookkeeping.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_pend       <= 1'b0;
            fifo_underflow <= 1'b0;
            fifo_data_out  <= '0;
            exp_q.delete();
            exp_uf_seen    <= 1'b0;
            exp_beats      <= 0;
            exp_ufc        <= 0;
        end else begin
            ret_pend       <= fifo_rd_en;
            fifo_underflow <= 1'b0;
            if (fifo_rd_en) begin
                fifo_data_out  <= fmem[rd_ptr];
                fifo_underflow <= uf_arm && (fmem[rd_ptr] == uf_word);
                rd_ptr         <= rd_ptr + 1;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (exp_beats < 65535) exp_beats <= exp_beats + 1;
            end
            if (flush) begin
                exp_q.delete();
            end else if (ret_pend) begin
                if (fifo_underflow) begin
                    exp_uf_seen <= 1'b1;
                    if (exp_ufc < 65535) exp_ufc <= exp_ufc + 1;
                end else begin
                    exp_q.push_back(fifo_data_out);
                end
            end
        end
    end

    function automatic void check(string n, int a, int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     n, a, a, e, e, cyc);
        end
    endfunction

    // Monitor
    always @(negedge clk) begin
        chk_t c;
        int   held;
        bit   pop;
        int   e_beat;
        int   e_ufc;
        while (req_rd < req_wr) begin
            c = req_arr[req_rd % 256];
            check(c.name, c.act, c.expv);
            req_rd++;
        end
        if (rst_n === 1'b1) begin
            pop  = m_valid && m_ready;
            held = exp_q.size() + int'(ret_pend) - int'(pop);
`ifdef FIFO_RD_ADAPTER_STATS_EN
            e_beat = exp_beats;
            e_ufc  = exp_ufc;
`else
            e_beat = 0;
            e_ufc  = 0;
`endif
            check("m_valid", int'(m_valid), (exp_q.size() != 0) ? 1 : 0);
            if (m_valid && exp_q.size() > 0) check("m_data", int'(m_data), int'(exp_q[0]));
            check("two_push", (exp_q.size() <= 2) ? 1 : 0, 1);
            check("rd_en", int'(fifo_rd_en), (!flush && !fifo_empty && held < 2) ? 1 : 0);
            check("uf_seen", int'(underflow_seen), int'(exp_uf_seen));
            check("beat_cnt", int'(beat_cnt), e_beat);
            check("uf_cnt", int'(underflow_cnt), e_ufc);
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            if (pop) begin
                dlv_data.push_back(m_data);
                dlv_cyc.push_back(cyc);
            end
        end
    end

    task automatic req(input string n, input int a, input int e);
        req_arr[req_wr % 256] = '{n, a, e};
        req_wr++;
    endtask

    task automatic load(input logic [W-1:0] w);
        fmem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic wait_dlv(input int target, input int budget);
        int k = 0;
        while (dlv_data.size() < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        req("delivered_count", dlv_data.size(), target);
    endtask

    task automatic req_reset_values(input string tag);
        req({tag, "_rd_en"},   int'(fifo_rd_en),     0);
        req({tag, "_m_valid"}, int'(m_valid),        0);
        req({tag, "_m_data"},  int'(m_data),         0);
        req({tag, "_uf_seen"}, int'(underflow_seen), 0);
        req({tag, "_beat"},    int'(beat_cnt),       0);
        req({tag, "_ufcnt"},   int'(underflow_cnt),  0);
    endtask

    initial begin
        int b;
        int r;
        int n;
        int k;
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        uf_arm  = 1'b0;
        uf_word = '0;
        @(posedge clk); #1;
        req_reset_values("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming: 8 beats back-to-back, two cycles after the first read
        m_ready = 1'b1;
        b = dlv_data.size();
        r = rd_cyc.size();
        for (int i = 1; i <= 8; i++) load(W'(i));
        wait_dlv(b + 8, 60);
        if (dlv_data.size() >= b + 8) begin
            req("first_latency", dlv_cyc[b] - rd_cyc[r], 2);
            req("burst_span", dlv_cyc[b+7] - dlv_cyc[b], 7);
            for (int i = 0; i < 8; i++) req("stream_data", int'(dlv_data[b+i]), i + 1);
        end

        // Back-pressure: only two reads while stalled, head word held
        m_ready = 1'b0;
        b = dlv_data.size();
        r = rd_cyc.size();
        for (int i = 0; i < 8; i++) load(W'(16'h0011 + i));
        repeat (10) @(posedge clk);
        #1;
        req("bp_reads", rd_cyc.size() - r, 2);
        req("bp_valid", int'(m_valid), 1);
        req("bp_data", int'(m_data), 16'h0011);
        m_ready = 1'b1;
        wait_dlv(b + 8, 60);
        if (dlv_data.size() >= b + 8)
            for (int i = 0; i < 8; i++) req("bp_order", int'(dlv_data[b+i]), 16'h0011 + i);

        // Forced underflow on the second returned word
        b = dlv_data.size();
        uf_word = 16'h00BB;
        uf_arm  = 1'b1;
        load(16'h00AA); load(16'h00BB); load(16'h00CC);
        wait_dlv(b + 2, 40);
        repeat (3) @(posedge clk);
        #1;
        uf_arm = 1'b0;
        req("uf_count_dlv", dlv_data.size() - b, 2);
        if (dlv_data.size() >= b + 2) begin
            req("uf_first", int'(dlv_data[b]), 16'h00AA);
            req("uf_next", int'(dlv_data[b+1]), 16'h00CC);
        end
        req("uf_sticky", int'(underflow_seen), 1);

        // Flush with one buffered word and one read in flight
        m_ready = 1'b0;
        b = dlv_data.size();
        for (int i = 0; i < 5; i++) load(W'(16'h0031 + i));
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        req("flush_valid", int'(m_valid), 0);
        m_ready = 1'b1;
        wait_dlv(b + 3, 40);
        if (dlv_data.size() >= b + 3) begin
            req("flush_pre", int'(dlv_data[b]), 16'h0031);
            req("flush_resume", int'(dlv_data[b+1]), 16'h0034);
            req("flush_last", int'(dlv_data[b+2]), 16'h0035);
        end

        // Random stall and random arrival over 64 words
        b = dlv_data.size();
        n = 0;
        k = 0;
        while ((n < 64 || dlv_data.size() < b + 64) && k < 3000) begin
            @(posedge clk);
            #1;
            m_ready = 1'($urandom_range(0, 1));
            if (n < 64 && $urandom_range(0, 1) == 1) begin
                load(W'($urandom));
                n++;
            end
            k++;
        end
        req("rand_count", dlv_data.size() - b, 64);

        // Reset mid-stream with the buffer full
        m_ready = 1'b0;
        b = dlv_data.size();
        for (int i = 0; i < 6; i++) load(W'(16'h0041 + i));
        repeat (4) @(posedge clk);
        #1;
        req("pre_rst_valid", int'(m_valid), 1);
        rst_n = 1'b0;
        #1;
        req_reset_values("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        wait_dlv(b + 4, 40);
        if (dlv_data.size() >= b + 4)
            for (int i = 0; i < 4; i++) req("post_rst", int'(dlv_data[b+i]), 16'h0043 + i);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
